fg_burst_sched: RTL and testbench
=================================

// Module: fg_burst_sched
// PURPOSE
// Multi-flow, rate-controlled burst scheduler for the flow generator. Accepts flow
// descriptors into a table of 2**FLOW_ADDR_WIDTH slots and round-robin scans the slots.
// Emits burst descriptors (dest, length, flow index, last) paced by a per-flow
// num/denom rate. Generalises widths and adds backpressure-safe issue, per-flow abort,
// an admission enable and zero-length handling. Sits between the descriptor source
// and the packet generator.
// PARAMETERS
// FLOW_ADDR_WIDTH  5   log2 of flow-table slots
// DEST_WIDTH       8   destination field width
// LEN_WIDTH        32  flow and burst length width
// RATE_WIDTH       16  rate_num/rate_denom width
// RATE_SCALE       8   credit multiplier; credit per visit C = rate_num*RATE_SCALE*2**FLOW_ADDR_WIDTH
// PORTS
// clk                  in   1    clock
// rst                  in   1    asynchronous reset, active-high
// enable               in   1    1 = admit new descriptors
// input_fd_valid       in   1    flow descriptor valid
// input_fd_ready       out  1    descriptor accepted this cycle (combinational)
// input_fd_dest        in   DEST_WIDTH   destination
// input_fd_rate_num    in   RATE_WIDTH   rate numerator
// input_fd_rate_denom  in   RATE_WIDTH   rate denominator
// input_fd_len         in   LEN_WIDTH    total flow length
// input_fd_burst_len   in   LEN_WIDTH    max burst length
// abort_req            in   1    abort request; held until abort_ack
// abort_flow           in   FLOW_ADDR_WIDTH  slot to abort
// abort_ack            out  1    one-cycle abort completion pulse
// output_bd_valid      out  1    burst descriptor valid
// output_bd_ready      in   1    burst descriptor ready
// output_bd_dest       out  DEST_WIDTH   burst destination
// output_bd_burst_len  out  LEN_WIDTH    burst length
// output_bd_flow       out  FLOW_ADDR_WIDTH  originating slot
// output_bd_last       out  1    final burst of the flow
// busy                 out  1    registered: active_flows != 0
// active_flows         out  FLOW_ADDR_WIDTH+1  count of active slots (full count representable)
// BEHAVIOUR
// - Reset: all slots inactive, scan pointer 0, skid buffer empty. Every output is 0.
//   Reset mid-burst discards all state; no partial descriptor appears afterwards.
// - Scan: one slot is visited per cycle, pointer increments mod 2**FLOW_ADDR_WIDTH.
//   A slot's state write completes before its next visit.
// - Slot state: active, dest, num, denom, len, burst_len, delay.
//   delay width is LEN_WIDTH+RATE_WIDTH+1, saturating add, floor at 0.
// - Per visit, first matching rule applies:
//   1 abort_req && abort_flow==slot: clear active (decrement count if it was active),
//     pulse abort_ack, no burst. The slot admits nothing this visit.
//   2 active && delay>=C: delay-=C.
//   3 active && delay<C && skid can accept: emit burst of min(len,burst_len).
//     If len>burst_len: len-=burst_len, delay=delay+burst_len*denom-C, last=0.
//     Otherwise: emit len, last=1, clear slot, decrement count.
//   4 active && delay<C && skid full: no state change; retried on next visit.
//     Bursts are never dropped.
//   5 inactive && enable && input_fd_valid: input_fd_ready=1 that cycle.
//     len==0: descriptor consumed, slot stays inactive, nothing emitted.
//     burst_len==0: treated as burst_len=len.
//     Otherwise: activate, delay=0, increment count.
// - input_fd_ready is 0 whenever rule 5 does not fire, including when all slots are active.
// - Simultaneous admit and last-burst in one cycle: the count is net-correct (+1-1=0).
// - Output: 2-entry skid (output reg + temp reg), AXI-style valid/ready. valid never
//   drops without a handshake, and data is stable while valid&&!ready.
//   Latency from issue cycle to output_bd_valid is 1 cycle.
// - "Skid can accept" = temp register empty.
// TESTING
// Parameters for all tests: FLOW_ADDR_WIDTH=2, RATE_SCALE=1, so C = 4*num.
// 1 Flow len=1000, burst=400, num=1, denom=1, ready=1 -> bursts 400,400,200, last only
//   on 200. Burst starts spaced 400+-4 cycles. active_flows returns to 0, busy falls.
// 2 Five descriptors offered back-to-back -> four accepted, active_flows=4,
//   input_fd_ready=0 until a slot frees.
// 3 output_bd_ready=0 for 200 cycles with 4 active flows -> no burst lost or duplicated.
//   Output data stable while stalled. Per-flow length sums equal len after release.
// 4 abort_req on slot 1 mid-flow -> abort_ack within 4 cycles, no further bursts with
//   output_bd_flow=1, active_flows decrements by 1.
// 5 Descriptor len=0 -> accepted, no burst, active_flows unchanged.
//   Descriptor len=10, burst_len=0 -> one burst of 10, last=1.
// 6 Assert rst for 1 cycle mid-stream -> all outputs 0 immediately.
//   A new descriptor len=8, burst=8 afterwards yields a single burst of 8.

Source files
------------

// File: rtl/fg_burst_sched.sv
// fg_burst_sched: round-robin, rate-paced burst scheduler for the flow generator.
// Flow descriptors are admitted into a slot table that is scanned one slot per
// cycle. Each visit either spends credit, issues a burst into a two-entry skid
// buffer, aborts the slot, or admits a new descriptor into an idle slot.
module fg_burst_sched #(
   parameter int FLOW_ADDR_WIDTH = 5,
   parameter int DEST_WIDTH      = 8,
   parameter int LEN_WIDTH       = 32,
   parameter int RATE_WIDTH      = 16,
   parameter int RATE_SCALE      = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       input_fd_valid,
   output logic                       input_fd_ready,
   input  logic [DEST_WIDTH-1:0]      input_fd_dest,
   input  logic [RATE_WIDTH-1:0]      input_fd_rate_num,
   input  logic [RATE_WIDTH-1:0]      input_fd_rate_denom,
   input  logic [LEN_WIDTH-1:0]       input_fd_len,
   input  logic [LEN_WIDTH-1:0]       input_fd_burst_len,
   input  logic                       abort_req,
   input  logic [FLOW_ADDR_WIDTH-1:0] abort_flow,
   output logic                       abort_ack,
   output logic                       output_bd_valid,
   input  logic                       output_bd_ready,
   output logic [DEST_WIDTH-1:0]      output_bd_dest,
   output logic [LEN_WIDTH-1:0]       output_bd_burst_len,
   output logic [FLOW_ADDR_WIDTH-1:0] output_bd_flow,
   output logic                       output_bd_last,
   output logic                       busy,
   output logic [FLOW_ADDR_WIDTH:0]   active_flows
);

   localparam int NSLOT    = 2 ** FLOW_ADDR_WIDTH;
   localparam int DELAY_W  = LEN_WIDTH + RATE_WIDTH + 1;
   localparam int PROD_W   = LEN_WIDTH + RATE_WIDTH;
   localparam int CRED_MUL = RATE_SCALE * NSLOT;
   localparam int CRED_W   = RATE_WIDTH + $clog2(CRED_MUL + 1);

   // Credit earned per visit: rate_num scaled by RATE_SCALE and the scan period.
   function automatic logic [DELAY_W-1:0] visit_credit(input logic [RATE_WIDTH-1:0] num);
      logic [CRED_W-1:0] c;
      c = CRED_W'(num) * CRED_W'(CRED_MUL);
      return DELAY_W'(c);
   endfunction

   // Saturating add of a burst cost onto the delay accumulator.
   function automatic logic [DELAY_W-1:0] sat_add(input logic [DELAY_W-1:0] a,
                                                  input logic [PROD_W-1:0]  b);
      logic [DELAY_W:0] s;
      s = {1'b0, a} + {2'b00, b};
      return s[DELAY_W] ? {DELAY_W{1'b1}} : s[DELAY_W-1:0];
   endfunction

   // Subtraction that floors at zero instead of wrapping.
   function automatic logic [DELAY_W-1:0] sub_floor(input logic [DELAY_W-1:0] a,
                                                    input logic [DELAY_W-1:0] b);
      logic signed [DELAY_W:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return d[DELAY_W] ? '0 : d[DELAY_W-1:0];
   endfunction

   // Slot table
   logic [NSLOT-1:0]           slot_act;
   logic [DEST_WIDTH-1:0]      slot_dest  [NSLOT];
   logic [RATE_WIDTH-1:0]      slot_num   [NSLOT];
   logic [RATE_WIDTH-1:0]      slot_denom [NSLOT];
   logic [LEN_WIDTH-1:0]       slot_len   [NSLOT];
   logic [LEN_WIDTH-1:0]       slot_bl    [NSLOT];
   logic [DELAY_W-1:0]         slot_delay [NSLOT];

   logic [FLOW_ADDR_WIDTH-1:0] ptr;
   logic [FLOW_ADDR_WIDTH:0]   cnt;
   logic [FLOW_ADDR_WIDTH:0]   cnt_nxt;

   // Visit stage (p0) signals
   logic                       cur_act;
   logic [DEST_WIDTH-1:0]      cur_dest;
   logic [RATE_WIDTH-1:0]      cur_num;
   logic [RATE_WIDTH-1:0]      cur_denom;
   logic [LEN_WIDTH-1:0]       cur_len;
   logic [LEN_WIDTH-1:0]       cur_bl;
   logic [DELAY_W-1:0]         cur_delay;
   logic [DELAY_W-1:0]         credit_p0;

   logic                       act_nxt;
   logic [DEST_WIDTH-1:0]      dest_nxt;
   logic [RATE_WIDTH-1:0]      num_nxt;
   logic [RATE_WIDTH-1:0]      denom_nxt;
   logic [LEN_WIDTH-1:0]       len_nxt;
   logic [LEN_WIDTH-1:0]       bl_nxt;
   logic [DELAY_W-1:0]         delay_nxt;
   logic                       inc;
   logic                       dec;
   logic                       ack_nxt;
   logic                       fd_take;

   logic                       vld_p0;
   logic [DEST_WIDTH-1:0]      dest_p0;
   logic [LEN_WIDTH-1:0]       len_p0;
   logic [FLOW_ADDR_WIDTH-1:0] flow_p0;
   logic                       last_p0;

   // Output register (p1) and skid register
   logic                       vld_p1;
   logic [DEST_WIDTH-1:0]      dest_p1;
   logic [LEN_WIDTH-1:0]       len_p1;
   logic [FLOW_ADDR_WIDTH-1:0] flow_p1;
   logic                       last_p1;

   logic                       skid_vld_p1;
   logic [DEST_WIDTH-1:0]      skid_dest_p1;
   logic [LEN_WIDTH-1:0]       skid_len_p1;
   logic [FLOW_ADDR_WIDTH-1:0] skid_flow_p1;
   logic                       skid_last_p1;

   logic                       out_load;

   // ---- stage p0: visit the slot under the scan pointer ----
   // Apply the first matching visit rule and compute the slot's write-back state.
   always_comb begin
      cur_act   = slot_act[ptr];
      cur_dest  = slot_dest[ptr];
      cur_num   = slot_num[ptr];
      cur_denom = slot_denom[ptr];
      cur_len   = slot_len[ptr];
      cur_bl    = slot_bl[ptr];
      cur_delay = slot_delay[ptr];
      credit_p0 = visit_credit(cur_num);

      act_nxt   = cur_act;
      dest_nxt  = cur_dest;
      num_nxt   = cur_num;
      denom_nxt = cur_denom;
      len_nxt   = cur_len;
      bl_nxt    = cur_bl;
      delay_nxt = cur_delay;
      inc       = 1'b0;
      dec       = 1'b0;
      ack_nxt   = 1'b0;
      fd_take   = 1'b0;

      vld_p0    = 1'b0;
      dest_p0   = cur_dest;
      len_p0    = cur_len;
      flow_p0   = ptr;
      last_p0   = 1'b0;

      if (abort_req && (abort_flow == ptr)) begin
         act_nxt = 1'b0;
         dec     = cur_act;
         ack_nxt = 1'b1;
      end else if (cur_act) begin
         if (cur_delay >= credit_p0) begin
            delay_nxt = cur_delay - credit_p0;
         end else if (!skid_vld_p1) begin
            vld_p0 = 1'b1;
            if (cur_len > cur_bl) begin
               len_p0    = cur_bl;
               len_nxt   = cur_len - cur_bl;
               delay_nxt = sub_floor(sat_add(cur_delay, PROD_W'(cur_bl) * PROD_W'(cur_denom)),
                                     credit_p0);
            end else begin
               len_p0  = cur_len;
               last_p0 = 1'b1;
               act_nxt = 1'b0;
               dec     = 1'b1;
            end
         end
      end else if (enable && input_fd_valid) begin
         fd_take = 1'b1;
         if (input_fd_len != '0) begin
            act_nxt   = 1'b1;
            inc       = 1'b1;
            dest_nxt  = input_fd_dest;
            num_nxt   = input_fd_rate_num;
            denom_nxt = input_fd_rate_denom;
            len_nxt   = input_fd_len;
            bl_nxt    = (input_fd_burst_len == '0) ? input_fd_len : input_fd_burst_len;
            delay_nxt = '0;
         end
      end

      cnt_nxt = cnt + {{FLOW_ADDR_WIDTH{1'b0}}, inc} - {{FLOW_ADDR_WIDTH{1'b0}}, dec};
   end

   assign input_fd_ready = fd_take & ~rst;

   // Write back the visited slot's data fields; validity is tracked by slot_act.
   always_ff @(posedge clk) begin
      slot_dest[ptr]  <= dest_nxt;
      slot_num[ptr]   <= num_nxt;
      slot_denom[ptr] <= denom_nxt;
      slot_len[ptr]   <= len_nxt;
      slot_bl[ptr]    <= bl_nxt;
      slot_delay[ptr] <= delay_nxt;
   end

   // Scan pointer, slot activity, flow count and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr          <= '0;
         slot_act     <= '0;
         cnt          <= '0;
         busy         <= 1'b0;
         abort_ack    <= 1'b0;
      end else begin
         ptr           <= ptr + 1'b1;
         slot_act[ptr] <= act_nxt;
         cnt           <= cnt_nxt;
         busy          <= (cnt_nxt != '0);
         abort_ack     <= ack_nxt;
      end
   end

   assign active_flows = cnt;

   // ---- stage p1: output register with skid entry ----
   assign out_load = !vld_p1 || output_bd_ready;

   // Output register: refill from the skid entry first, otherwise from the visit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         dest_p1 <= '0;
         len_p1  <= '0;
         flow_p1 <= '0;
         last_p1 <= 1'b0;
      end else if (out_load) begin
         if (skid_vld_p1) begin
            vld_p1  <= 1'b1;
            dest_p1 <= skid_dest_p1;
            len_p1  <= skid_len_p1;
            flow_p1 <= skid_flow_p1;
            last_p1 <= skid_last_p1;
         end else if (vld_p0) begin
            vld_p1  <= 1'b1;
            dest_p1 <= dest_p0;
            len_p1  <= len_p0;
            flow_p1 <= flow_p0;
            last_p1 <= last_p0;
         end else begin
            vld_p1  <= 1'b0;
         end
      end
   end

   // Skid occupancy: fills when a burst issues into a stalled output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_vld_p1 <= 1'b0;
      end else if (out_load) begin
         skid_vld_p1 <= 1'b0;
      end else if (vld_p0) begin
         skid_vld_p1 <= 1'b1;
      end
   end

   // Skid data capture; only meaningful while skid_vld_p1 is set.
   always_ff @(posedge clk) begin
      if (!out_load && vld_p0) begin
         skid_dest_p1 <= dest_p0;
         skid_len_p1  <= len_p0;
         skid_flow_p1 <= flow_p0;
         skid_last_p1 <= last_p0;
      end
   end

   assign output_bd_valid     = vld_p1;
   assign output_bd_dest      = dest_p1;
   assign output_bd_burst_len = len_p1;
   assign output_bd_flow      = flow_p1;
   assign output_bd_last      = last_p1;

endmodule

// File: tb/tb_fg_burst_sched.sv
// tb_fg_burst_sched: directed bench for fg_burst_sched with a 4-slot table and
// unit rate scale, so each visit earns 4*rate_num credit.
module tb_fg_burst_sched;

   localparam int FAW = 2;
   localparam int DW  = 8;
   localparam int LW  = 32;
   localparam int RW  = 16;
   localparam int RS  = 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           enable = 1'b0;
   logic           input_fd_valid = 1'b0;
   logic           input_fd_ready;
   logic [DW-1:0]  input_fd_dest = '0;
   logic [RW-1:0]  input_fd_rate_num = '0;
   logic [RW-1:0]  input_fd_rate_denom = '0;
   logic [LW-1:0]  input_fd_len = '0;
   logic [LW-1:0]  input_fd_burst_len = '0;
   logic           abort_req = 1'b0;
   logic [FAW-1:0] abort_flow = '0;
   logic           abort_ack;
   logic           output_bd_valid;
   logic           output_bd_ready = 1'b1;
   logic [DW-1:0]  output_bd_dest;
   logic [LW-1:0]  output_bd_burst_len;
   logic [FAW-1:0] output_bd_flow;
   logic           output_bd_last;
   logic           busy;
   logic [FAW:0]   active_flows;

   fg_burst_sched #(
      .FLOW_ADDR_WIDTH(FAW), .DEST_WIDTH(DW), .LEN_WIDTH(LW),
      .RATE_WIDTH(RW), .RATE_SCALE(RS)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .input_fd_valid(input_fd_valid), .input_fd_ready(input_fd_ready),
      .input_fd_dest(input_fd_dest), .input_fd_rate_num(input_fd_rate_num),
      .input_fd_rate_denom(input_fd_rate_denom), .input_fd_len(input_fd_len),
      .input_fd_burst_len(input_fd_burst_len),
      .abort_req(abort_req), .abort_flow(abort_flow), .abort_ack(abort_ack),
      .output_bd_valid(output_bd_valid), .output_bd_ready(output_bd_ready),
      .output_bd_dest(output_bd_dest), .output_bd_burst_len(output_bd_burst_len),
      .output_bd_flow(output_bd_flow), .output_bd_last(output_bd_last),
      .busy(busy), .active_flows(active_flows)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Burst log, captured on the negative edge ahead of each handshake edge.
   int unsigned q_len[$];
   int          q_flow[$];
   int          q_dest[$];
   int          q_last[$];
   int          q_cyc[$];

   always @(negedge clk) begin
      if (!rst && output_bd_valid && output_bd_ready) begin
         q_len.push_back(output_bd_burst_len);
         q_flow.push_back(int'(output_bd_flow));
         q_dest.push_back(int'(output_bd_dest));
         q_last.push_back(int'(output_bd_last));
         q_cyc.push_back(cyc);
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_fd(input logic [DW-1:0] dest, input logic [RW-1:0] num,
                          input logic [RW-1:0] denom, input logic [LW-1:0] len,
                          input logic [LW-1:0] bl, output bit ok);
      ok = 1'b0;
      input_fd_dest       = dest;
      input_fd_rate_num   = num;
      input_fd_rate_denom = denom;
      input_fd_len        = len;
      input_fd_burst_len  = bl;
      input_fd_valid      = 1'b1;
      for (int i = 0; i < 12 && !ok; i++) begin
         @(negedge clk);
         if (input_fd_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      input_fd_valid = 1'b0;
   endtask

   task automatic abort_slot(input int s, output int waited);
      abort_req  = 1'b1;
      abort_flow = FAW'(s);
      waited     = 99;
      for (int i = 1; i <= 8 && waited == 99; i++) begin
         @(negedge clk);
         if (abort_ack) waited = i;
      end
      @(posedge clk);
      #1;
      abort_req = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int base, base2, acc, k, w, bad, nflow1, nother, nlast;
      int sum[4];
      int unsigned t2_len[5];
      logic [DW-1:0]  s_dest;
      logic [LW-1:0]  s_len;
      logic [FAW-1:0] s_flow;
      logic           s_last;

      t2_len = '{100, 90, 80, 70, 60};

      // Reset state
      step(3);
      check_val("rst_valid", output_bd_valid, 0);
      check_val("rst_ack", abort_ack, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_active", active_flows, 0);
      check_val("rst_ready", input_fd_ready, 0);
      rst = 1'b0;
      step(1);
      enable = 1'b1;

      // Test 1: single flow 1000/400 at unit rate
      base = q_len.size();
      send_fd(8'h11, 1, 1, 1000, 400, ok);
      check_val("t1_accept", ok, 1);
      check_val("t1_active1", active_flows, 1);
      check_val("t1_busy1", busy, 1);
      for (int i = 0; i < 1300 && q_len.size() < base + 3; i++) step(1);
      step(10);
      check_val("t1_count", q_len.size() - base, 3);
      if (q_len.size() >= base + 3) begin
         check_val("t1_len0", q_len[base], 400);
         check_val("t1_len1", q_len[base+1], 400);
         check_val("t1_len2", q_len[base+2], 200);
         check_val("t1_last0", q_last[base], 0);
         check_val("t1_last1", q_last[base+1], 0);
         check_val("t1_last2", q_last[base+2], 1);
         check_val("t1_dest", q_dest[base+2], 8'h11);
         w = q_cyc[base+1] - q_cyc[base];
         check_val("t1_gap0_ok", (w >= 396 && w <= 404) ? 1 : 0, 1);
         w = q_cyc[base+2] - q_cyc[base+1];
         check_val("t1_gap1_ok", (w >= 396 && w <= 404) ? 1 : 0, 1);
      end
      check_val("t1_active0", active_flows, 0);
      check_val("t1_busy0", busy, 0);

      // Test 2: five descriptors back to back while the output is stalled
      output_bd_ready = 1'b0;
      base = q_len.size();
      acc = 0;
      k = 0;
      input_fd_dest = 8'h20; input_fd_rate_num = 1; input_fd_rate_denom = 1;
      input_fd_len = t2_len[0]; input_fd_burst_len = 30;
      input_fd_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (input_fd_ready) begin
            acc++;
            if (k < 4) k++;
         end
         @(posedge clk);
         #1;
         input_fd_dest = DW'(8'h20 + k);
         input_fd_len  = t2_len[k];
      end
      input_fd_valid = 1'b0;
      check_val("t2_accepted", acc, 4);
      check_val("t2_active", active_flows, 4);
      check_val("t2_ready_full", input_fd_ready, 0);

      // Test 3: hold the output stalled for 200 cycles, then drain
      step(8);
      @(negedge clk);
      check_val("t3_stall_valid", output_bd_valid, 1);
      s_dest = output_bd_dest; s_len = output_bd_burst_len;
      s_flow = output_bd_flow; s_last = output_bd_last;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!output_bd_valid || output_bd_dest != s_dest || output_bd_burst_len != s_len ||
             output_bd_flow != s_flow || output_bd_last != s_last) bad++;
      end
      check_val("t3_stable", bad, 0);
      check_val("t3_no_hs", q_len.size() - base, 0);
      @(posedge clk);
      #1;
      output_bd_ready = 1'b1;
      for (int i = 0; i < 3000 && (active_flows != 0 || output_bd_valid); i++) step(1);
      check_val("t3_drained", active_flows, 0);
      for (int j = 0; j < 4; j++) sum[j] = 0;
      nlast = 0;
      for (int i = base; i < q_len.size(); i++) begin
         sum[q_dest[i] & 3] += int'(q_len[i]);
         nlast += q_last[i];
      end
      check_val("t3_sum20", sum[0], 100);
      check_val("t3_sum21", sum[1], 90);
      check_val("t3_sum22", sum[2], 80);
      check_val("t3_sum23", sum[3], 70);
      check_val("t3_count", q_len.size() - base, 13);
      check_val("t3_lasts", nlast, 4);

      // Test 4: abort slot 1 of four long flows
      acc = 0;
      for (int j = 0; j < 4; j++) begin
         send_fd(DW'(8'h30 + j), 1, 1, 1000, 10, ok);
         acc += int'(ok);
      end
      check_val("t4_accepted", acc, 4);
      check_val("t4_active4", active_flows, 4);
      step(40);
      abort_slot(1, w);
      check_val("t4_ack_in4", (w <= 4) ? 1 : 0, 1);
      check_val("t4_active3", active_flows, 3);
      base2 = q_len.size();
      step(100);
      nflow1 = 0;
      nother = 0;
      for (int i = base2; i < q_len.size(); i++) begin
         if (q_flow[i] == 1) nflow1++;
         else nother++;
      end
      check_val("t4_no_flow1", nflow1, 0);
      check_val("t4_others_run", (nother > 0) ? 1 : 0, 1);
      abort_slot(0, w);
      abort_slot(2, w);
      abort_slot(3, w);
      check_val("t4_active0", active_flows, 0);
      step(10);
      check_val("t4_busy0", busy, 0);

      // Test 5: zero-length flow, then zero burst length
      base = q_len.size();
      send_fd(8'h40, 1, 1, 0, 5, ok);
      check_val("t5_len0_accept", ok, 1);
      step(20);
      check_val("t5_len0_nobursts", q_len.size() - base, 0);
      check_val("t5_len0_active", active_flows, 0);
      send_fd(8'h41, 1, 1, 10, 0, ok);
      check_val("t5_bl0_accept", ok, 1);
      step(20);
      check_val("t5_bl0_count", q_len.size() - base, 1);
      if (q_len.size() == base + 1) begin
         check_val("t5_bl0_len", q_len[base], 10);
         check_val("t5_bl0_last", q_last[base], 1);
         check_val("t5_bl0_dest", q_dest[base], 8'h41);
      end
      check_val("t5_bl0_active", active_flows, 0);

      // Test 6: reset mid-stream, then a fresh short flow
      output_bd_ready = 1'b0;
      send_fd(8'h50, 1, 1, 1000, 400, ok);
      for (int i = 0; i < 20 && !output_bd_valid; i++) step(1);
      check_val("t6_pending", output_bd_valid, 1);
      rst = 1'b1;
      #1;
      check_val("t6_rst_valid", output_bd_valid, 0);
      check_val("t6_rst_len", output_bd_burst_len, 0);
      check_val("t6_rst_dest", output_bd_dest, 0);
      check_val("t6_rst_active", active_flows, 0);
      check_val("t6_rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      output_bd_ready = 1'b1;
      base = q_len.size();
      send_fd(8'h51, 1, 1, 8, 8, ok);
      check_val("t6_accept", ok, 1);
      step(30);
      check_val("t6_count", q_len.size() - base, 1);
      if (q_len.size() == base + 1) begin
         check_val("t6_len", q_len[base], 8);
         check_val("t6_last", q_last[base], 1);
         check_val("t6_dest", q_dest[base], 8'h51);
      end
      check_val("t6_active", active_flows, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
